// File: rtl/uart_hex_dump.sv
// uart_hex_dump: formats a snapshot of NUM_CH channel words into an ASCII hex
// line ("R0:00A3 R2:BEEF\n\r") and streams it one byte per transfer to a TX FIFO.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_data       - NUM_CH packed channel words, channel c at [c*DATA_W +: DATA_W]
//   i_ch_mask    - per-channel include mask
//   i_lz         - suppress leading zero nibbles
//   i_stb        - dump request (accepted only when idle with a non-zero mask)
//   o_busy       - dump in progress
//   o_byte       - ASCII byte offered downstream
//   o_byte_vld   - o_byte valid
//   i_byte_rdy   - downstream accepts o_byte this cycle
module uart_hex_dump #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_CH   = 4,
  parameter logic [7:0]  PFX_CHAR = "R"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH-1:0]        i_ch_mask,
  input  logic                     i_lz,
  input  logic                     i_stb,
  output logic                     o_busy,
  output logic [7:0]               o_byte,
  output logic                     o_byte_vld,
  input  logic                     i_byte_rdy
);

  localparam int unsigned NIB_N = DATA_W / 4;
  localparam int unsigned NIB_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PFX, S_IDX, S_COLON, S_NIB, S_SEP, S_NL, S_CR
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [NUM_CH*DATA_W-1:0]   cap_data;
  logic [NUM_CH-1:0]          cap_mask;
  logic                       cap_lz;
  logic [CH_W-1:0]            ch;
  logic [NIB_W-1:0]           nib;

  logic                       start;
  logic                       xfer;
  logic [DATA_W-1:0]          word;
  logic [CH_W-1:0]            first_ch;
  logic [CH_W-1:0]            next_ch;
  logic                       has_next;
  logic [NIB_W-1:0]           first_nib;

  function automatic logic [7:0] hex(input logic [3:0] n);
    hex = (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  assign start = (state == S_IDLE) && i_stb && (|i_ch_mask);
  assign xfer  = (state != S_IDLE) && i_byte_rdy;
  assign word  = cap_data[int'(ch)*DATA_W +: DATA_W];

  // Lowest enabled channel of the incoming mask; lowest captured channel above ch.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (i_ch_mask[c]) first_ch = CH_W'(c);
      if (cap_mask[c] && (c > int'(ch))) begin
        next_ch  = CH_W'(c);
        has_next = 1'b1;
      end
    end
  end

  // First nibble to print, chosen while leaving COLON so skipping costs no cycles.
  always_comb begin
    first_nib = '0;
    for (int i = 0; i < int'(NIB_N); i++) begin
      if (word[i*4 +: 4] != 4'h0) first_nib = NIB_W'(i);
    end
    if (!cap_lz) first_nib = NIB_W'(NIB_N - 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; non-idle states advance only on a byte transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PFX;
      S_PFX:   if (xfer) state_nxt = S_IDX;
      S_IDX:   if (xfer) state_nxt = S_COLON;
      S_COLON: if (xfer) state_nxt = S_NIB;
      S_NIB:   if (xfer && (nib == '0)) state_nxt = has_next ? S_SEP : S_NL;
      S_SEP:   if (xfer) state_nxt = S_PFX;
      S_NL:    if (xfer) state_nxt = S_CR;
      S_CR:    if (xfer) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state and counters, so o_byte holds during stalls.
  always_comb begin
    o_busy     = (state != S_IDLE);
    o_byte_vld = (state != S_IDLE);
    o_byte     = 8'h00;
    case (state)
      S_PFX:   o_byte = PFX_CHAR;
      S_IDX:   o_byte = hex(4'(ch));
      S_COLON: o_byte = 8'h3A;
      S_NIB:   o_byte = hex(word[int'(nib)*4 +: 4]);
      S_SEP:   o_byte = 8'h20;
      S_NL:    o_byte = 8'h0A;
      S_CR:    o_byte = 8'h0D;
      default: o_byte = 8'h00;
    endcase
  end

  // Capture registers plus channel / nibble counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data <= '0;
      cap_mask <= '0;
      cap_lz   <= 1'b0;
      ch       <= '0;
      nib      <= '0;
    end else if (start) begin
      cap_data <= i_data;
      cap_mask <= i_ch_mask;
      cap_lz   <= i_lz;
      ch       <= first_ch;
      nib      <= '0;
    end else if (xfer) begin
      case (state)
        S_COLON: nib <= first_nib;
        S_NIB:   if (nib != '0) nib <= nib - 1'b1;
        S_SEP:   ch <= next_ch;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_dump.sv
// Directed bench for uart_hex_dump (DATA_W=16, NUM_CH=4, PFX_CHAR="R").
module tb_uart_hex_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] i_data = '0;
  logic [3:0]  i_ch_mask = '0;
  logic        i_lz = 1'b0;
  logic        i_stb = 1'b0;
  logic        o_busy;
  logic [7:0]  o_byte;
  logic        o_byte_vld;
  logic        i_byte_rdy = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  localparam logic [63:0] BASIC = {16'h5678, 16'hBEEF, 16'h1234, 16'h00A3};

  uart_hex_dump #(.DATA_W(16), .NUM_CH(4), .PFX_CHAR("R")) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_ch_mask(i_ch_mask), .i_lz(i_lz),
    .i_stb(i_stb), .o_busy(o_busy), .o_byte(o_byte), .o_byte_vld(o_byte_vld),
    .i_byte_rdy(i_byte_rdy)
  );

  always #5 clk = ~clk;

  function automatic void mk_exp(input string s);
    exp_q = {};
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
  endfunction

  function automatic bit same();
    if (got.size() != exp_q.size()) return 1'b0;
    foreach (got[i]) if (got[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Called on a negedge: pulse i_stb for one cycle with the given settings.
  task automatic start_dump(input logic [3:0] m, input logic [63:0] d, input bit lz);
    i_ch_mask = m;
    i_data    = d;
    i_lz      = lz;
    i_stb     = 1'b1;
    @(negedge clk);
    i_stb     = 1'b0;
  endtask

  // Collect transferred bytes until o_busy drops; count o_byte changes during stalls.
  task automatic collect(input bit rnd, output int cycles, output int stall_bad);
    logic [7:0] prev = 8'h00;
    bit prev_stall = 1'b0;
    got = {};
    cycles = 0;
    stall_bad = 0;
    while (o_busy && cycles < 400) begin
      i_byte_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (o_byte !== prev)) stall_bad++;
      if (o_byte_vld && i_byte_rdy) got.push_back(o_byte);
      prev_stall = o_byte_vld && !i_byte_rdy;
      prev = o_byte;
      cycles++;
      @(negedge clk);
    end
    i_byte_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_byte_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", o_byte_vld); end
    n_cmp++; if (o_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", o_byte); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, sb;
    start_dump(4'b0101, BASIC, 1'b0);
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", o_busy); end
    collect(1'b0, cyc, sb);
    mk_exp("R0:00A3 R2:BEEF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL basic_stream: got %s want %s", q2s(got), q2s(exp_q)); end
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL basic_cycles: got %0d want 17", cyc); end
  endtask

  task automatic test_lz();
    int cyc, sb;
    start_dump(4'b0101, BASIC, 1'b1);
    collect(1'b0, cyc, sb);
    mk_exp("R0:A3 R2:BEEF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL lz_stream: got %s want %s", q2s(got), q2s(exp_q)); end
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL lz_cycles: got %0d want 15", cyc); end
    start_dump(4'b1010, {16'h0F00, 16'hFFFF, 16'h0000, 16'hFFFF}, 1'b1);
    collect(1'b0, cyc, sb);
    mk_exp("R1:0 R3:F00");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL lz_zero_stream: got %s want %s", q2s(got), q2s(exp_q)); end
  endtask

  task automatic test_all_channels();
    int cyc, sb;
    start_dump(4'b1111, {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123}, 1'b0);
    collect(1'b0, cyc, sb);
    mk_exp("R0:0123 R1:4567 R2:89AB R3:CDEF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL all_stream: got %s want %s", q2s(got), q2s(exp_q)); end
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL all_cycles: got %0d want 33", cyc); end
  endtask

  task automatic test_stall();
    int cyc, sb;
    start_dump(4'b0101, BASIC, 1'b0);
    collect(1'b1, cyc, sb);
    mk_exp("R0:00A3 R2:BEEF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL stall_stream: got %s want %s", q2s(got), q2s(exp_q)); end
    n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", sb); end
  endtask

  task automatic test_ignore_and_capture();
    int cyc, sb;
    i_ch_mask = 4'b0000;
    i_stb = 1'b1;
    @(negedge clk);
    i_stb = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mask0_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_byte_vld !== 1'b0) begin n_bad++; $display("FAIL mask0_vld: got %b want 0", o_byte_vld); end
    // Accepted request, then a second request plus new inputs while busy.
    i_ch_mask = 4'b0101; i_data = BASIC; i_lz = 1'b0; i_byte_rdy = 1'b0; i_stb = 1'b1;
    @(negedge clk);
    i_ch_mask = 4'b1111; i_data = {4{16'hFFFF}}; i_lz = 1'b1;
    @(negedge clk);
    i_stb = 1'b0;
    collect(1'b0, cyc, sb);
    mk_exp("R0:00A3 R2:BEEF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL capture_stream: got %s want %s", q2s(got), q2s(exp_q)); end
    repeat (3) @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL busy_stb_ignored: got busy %b want 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, sb;
    start_dump(4'b0101, BASIC, 1'b0);
    collect(1'b0, cyc, sb);
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL b2b_first_cycles: got %0d want 17", cyc); end
    start_dump(4'b0001, {48'h0, 16'hFFFF}, 1'b1);
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy %b want 1", o_busy); end
    collect(1'b0, cyc, sb);
    mk_exp("R0:FFFF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL b2b_stream: got %s want %s", q2s(got), q2s(exp_q)); end
  endtask

  task automatic test_reset_mid();
    int cyc, sb;
    i_byte_rdy = 1'b1;
    start_dump(4'b0101, BASIC, 1'b0);
    repeat (5) @(negedge clk);
    i_byte_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (o_byte_vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_vld: got %b want 0", o_byte_vld); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_byte !== 8'h00) begin n_bad++; $display("FAIL rstmid_byte: got %h want 00", o_byte); end
    i_byte_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_byte_vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: got %b want 0", o_byte_vld); end
    start_dump(4'b0101, BASIC, 1'b0);
    collect(1'b0, cyc, sb);
    mk_exp("R0:00A3 R2:BEEF");
    n_cmp++; if (!same()) begin n_bad++; $display("FAIL rstmid_fresh: got %s want %s", q2s(got), q2s(exp_q)); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_lz();
    test_all_channels();
    test_stall();
    test_ignore_and_capture();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_hex_dump.md
UART_HEX_DUMP -- requirements
Module: uart_hex_dump

Interface
REQ-001 Parameter DATA_W, default 16, width in bits of each channel word; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter NUM_CH, default 4, number of channel words per dump; range 1..16.
REQ-003 Parameter PFX_CHAR, default "R", 8-bit ASCII prefix character emitted before each channel index.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_data  input  NUM_CH*DATA_W  channel words; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-007 i_ch_mask  input  NUM_CH  per-channel enable; bit c=1 includes channel c in the dump.
REQ-008 i_lz  input  1  1 = suppress leading zero nibbles.
REQ-009 i_stb  input  1  single-cycle dump request.
REQ-010 o_busy  output  1  dump in progress.
REQ-011 o_byte  output  8  ASCII byte to downstream TX FIFO.
REQ-012 o_byte_vld  output  1  o_byte valid.
REQ-013 i_byte_rdy  input  1  downstream can accept a byte (e.g. ~fifo_full).

Function
REQ-014 On i_stb in IDLE with i_ch_mask!=0, the block SHALL capture i_data, i_ch_mask and i_lz into internal registers in that same cycle and enter PFX; o_busy=1 from the next cycle.
REQ-015 i_stb while o_busy=1, or with i_ch_mask==0, SHALL be ignored (no capture, no bytes emitted).
REQ-016 Output sequence: for each captured-enabled channel c, in ascending order: PFX_CHAR, hex digit of c, ":", hex digits of the word MSB-nibble first; consecutive channels separated by " " (0x20); sequence terminated by "\n" (0x0A) then "\r" (0x0D).
REQ-017 Hex digits SHALL be uppercase ASCII "0"-"9", "A"-"F".
REQ-018 With captured i_lz=0, exactly DATA_W/4 digits per channel; with i_lz=1, leading "0" nibbles are skipped but at least one digit (the LSB nibble) is always emitted.
REQ-019 States: IDLE, PFX, IDX, COLON, NIB, SEP, NL, CR; each non-IDLE state except the skip case in REQ-018 emits exactly one byte.
REQ-020 o_byte_vld=1 in every non-IDLE state; a byte transfers in a cycle with o_byte_vld & i_byte_rdy; state/nibble/channel counters advance only on transfer.
REQ-021 o_byte SHALL be stable while o_byte_vld=1 and i_byte_rdy=0.
REQ-022 Leading-zero skipping SHALL cost no output cycles: the first emitted digit is selected when entering NIB.
REQ-023 Transitions: PFX->IDX->COLON->NIB; NIB stays until last nibble, then SEP if a higher enabled channel remains, else NL; SEP->PFX of next enabled channel; NL->CR->IDLE.
REQ-024 On the CR transfer o_busy SHALL drop to 0 in the next cycle; an i_stb in that next cycle SHALL be accepted.
REQ-025 Throughput with i_byte_rdy held 1: one byte per clock, no bubbles, including between channels.
REQ-026 Changes on i_data/i_ch_mask/i_lz during a dump SHALL NOT affect the dump in progress.

Reset
REQ-027 rst SHALL force IDLE, o_busy=0, o_byte_vld=0, o_byte=8'h00, clear counters and captured registers.
REQ-028 rst asserted mid-dump SHALL abort immediately; no further bytes are emitted and the partial line is not terminated.

Verification
REQ-029 DATA_W=16, NUM_CH=4, mask=4'b0101, data ch0=16'h00A3, ch2=16'hBEEF, i_lz=0, rdy=1 -> "R0:00A3 R2:BEEF\n\r", 17 bytes on 17 consecutive cycles.
REQ-030 Same data, i_lz=1 -> "R0:A3 R2:BEEF\n\r"; ch word 16'h0000 with i_lz=1 -> "R<n>:0".
REQ-031 i_byte_rdy toggled pseudo-randomly -> identical byte stream; o_byte stable across every stalled cycle.
REQ-032 i_stb during busy and i_stb with mask=0 -> ignored, no extra bytes; i_stb in cycle after CR -> new dump starts.
REQ-033 i_data changed one cycle after i_stb -> output reflects captured value only.
REQ-034 rst after 5th byte of a dump -> o_byte_vld=0 next cycle, o_busy=0, next i_stb produces a complete fresh dump.
